// File: rtl/jtag_dbg_pkg.sv
// Shared layout definitions for the JTAG debug address/control register.
// The scan word is LSB first: ADDR, WR, INC, ERR, LEN_ERR, DBG.
package jtag_dbg_pkg;

  // Control nibble between ADDR and DBG; wr sits at the lowest bit position.
  typedef struct packed {
    logic len_err;
    logic err;
    logic inc;
    logic wr;
  } ctl_t;

  localparam int CTL_W = $bits(ctl_t);

  typedef enum logic [1:0] {
    OP_IDLE    = 2'd0,
    OP_CAPTURE = 2'd1,
    OP_SHIFT   = 2'd2
  } sr_op_t;

  function automatic int srw(input int aw, input int dbgw);
    return aw + CTL_W + dbgw;
  endfunction

  function automatic int addr_lsb();
    return 0;
  endfunction

  function automatic int wr_bit(input int aw);
    return aw;
  endfunction

  function automatic int inc_bit(input int aw);
    return aw + 1;
  endfunction

  function automatic int err_bit(input int aw);
    return aw + 2;
  endfunction

  function automatic int len_err_bit(input int aw);
    return aw + 3;
  endfunction

  function automatic int dbg_lsb(input int aw);
    return aw + CTL_W;
  endfunction

endpackage

// File: rtl/jtag_addr_reg.sv
// JTAG user data register holding debug field, mode bits and bus address,
// with auto-increment, update strobe, sticky errors and scan-length checking.
module jtag_addr_reg
  import jtag_dbg_pkg::*;
#(
  parameter int          AW     = 32,
  parameter int          DBGW   = 6,
  parameter int unsigned STRIDE = 4
) (
  input  logic            TCK,
  input  logic            RESET,
  input  logic            SEL,
  input  logic            CAPTURE,
  input  logic            SHIFT,
  input  logic            UPDATE,
  input  logic            TDI,
  output logic            TDO,
  input  logic            ACC,
  input  logic            BUS_ERR,
  output logic [DBGW-1:0] DBG,
  output logic            INC,
  output logic            WR,
  output logic [AW-1:0]   ADDR,
  output logic            UPD_STB,
  output logic            ERR,
  output logic            LEN_ERR
);

  localparam int SRW   = srw(AW, DBGW);
  localparam int CW    = $clog2(SRW + 2);
  localparam int A_LSB = addr_lsb();
  localparam int WRB   = wr_bit(AW);
  localparam int D_LSB = dbg_lsb(AW);

  localparam logic [CW-1:0] CNT_FULL = CW'(SRW);
  localparam logic [CW-1:0] CNT_SAT  = CW'(SRW + 1);
  localparam logic [AW-1:0] STEP     = AW'(STRIDE);

  // Over-long scans park at SRW+1 so they can never alias back to SRW.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (c == CNT_SAT) ? c : c + CW'(1);
  endfunction

  sr_op_t          op;
  ctl_t            cap_ctl;
  ctl_t            upd_ctl;
  logic [SRW-1:0]  sr;
  logic [SRW-1:0]  cap_word;
  logic [CW-1:0]   cnt;
  logic            upd_sel;
  logic            accept;
  logic [AW-1:0]   upd_addr;
  logic [DBGW-1:0] upd_dbg;

  always_comb begin
    op = OP_IDLE;
    if (SEL && CAPTURE)
      op = OP_CAPTURE;
    else if (SEL && SHIFT)
      op = OP_SHIFT;
  end

  assign cap_ctl  = {LEN_ERR, ERR, INC, WR};
  assign cap_word = {DBG, cap_ctl, ADDR};

  assign upd_addr = sr[A_LSB +: AW];
  assign upd_ctl  = sr[WRB +: CTL_W];
  assign upd_dbg  = sr[D_LSB +: DBGW];

  assign upd_sel  = SEL & UPDATE;
  assign accept   = upd_sel && (cnt == CNT_FULL);

  assign TDO = sr[0];

  // Scan path: shift register and bit counter
  always_ff @(posedge TCK or posedge RESET) begin
    if (RESET) begin
      sr  <= '0;
      cnt <= '0;
    end else begin
      case (op)
        OP_CAPTURE: begin
          sr  <= cap_word;
          cnt <= '0;
        end
        OP_SHIFT: begin
          sr  <= {TDI, sr[SRW-1:1]};
          cnt <= sat_inc(cnt);
        end
        default: ;
      endcase
    end
  end

  // Parallel register: update load, auto-increment, sticky flags
  always_ff @(posedge TCK or posedge RESET) begin
    if (RESET) begin
      DBG     <= '0;
      INC     <= 1'b0;
      WR      <= 1'b0;
      ADDR    <= '0;
      UPD_STB <= 1'b0;
      ERR     <= 1'b0;
      LEN_ERR <= 1'b0;
    end else begin
      UPD_STB <= accept;

      if (accept) begin
        DBG  <= upd_dbg;
        INC  <= upd_ctl.inc;
        WR   <= upd_ctl.wr;
        ADDR <= upd_addr;
      end else if (ACC && INC) begin
        ADDR <= ADDR + STEP;
      end

      // A bus error in the same cycle as a W1C clear must not be lost.
      if (BUS_ERR)
        ERR <= 1'b1;
      else if (accept && upd_ctl.err)
        ERR <= 1'b0;

      if (upd_sel && !accept)
        LEN_ERR <= 1'b1;
      else if (accept && upd_ctl.len_err)
        LEN_ERR <= 1'b0;
    end
  end

endmodule

// File: tb/tb_jtag_addr_reg.sv
// Directed bench for jtag_addr_reg with a queue-based reference model
// compared against the DUT on every TCK cycle.
module tb_jtag_addr_reg;

  localparam int          AW     = 32;
  localparam int          DBGW   = 6;
  localparam int unsigned STRIDE = 4;
  localparam int          SRW    = AW + 4 + DBGW;

  logic            TCK, RESET, SEL, CAPTURE, SHIFT, UPDATE, TDI, TDO, ACC, BUS_ERR;
  logic [DBGW-1:0] DBG;
  logic            INC, WR, UPD_STB, ERR, LEN_ERR;
  logic [AW-1:0]   ADDR;

  int tests = 0;
  int fails = 0;

  jtag_addr_reg #(.AW(AW), .DBGW(DBGW), .STRIDE(STRIDE)) dut (
    .TCK(TCK), .RESET(RESET), .SEL(SEL), .CAPTURE(CAPTURE), .SHIFT(SHIFT),
    .UPDATE(UPDATE), .TDI(TDI), .TDO(TDO), .ACC(ACC), .BUS_ERR(BUS_ERR),
    .DBG(DBG), .INC(INC), .WR(WR), .ADDR(ADDR), .UPD_STB(UPD_STB),
    .ERR(ERR), .LEN_ERR(LEN_ERR)
  );

  initial TCK = 1'b0;
  always #5 TCK = ~TCK;

  // Reference model state
  logic [DBGW-1:0] m_dbg;
  logic            m_inc, m_wr, m_err, m_len, m_stb;
  logic [AW-1:0]   m_addr;
  bit              sq[$];
  int              n_sh;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [SRW-1:0] word(input logic [DBGW-1:0] d, input logic len,
                                          input logic err, input logic inc,
                                          input logic wr, input logic [AW-1:0] a);
    return {d, len, err, inc, wr, a};
  endfunction

  task automatic model_reset();
    m_dbg = '0; m_inc = 0; m_wr = 0; m_err = 0; m_len = 0; m_stb = 0; m_addr = '0;
    sq = {};
    for (int i = 0; i < SRW; i++) sq.push_back(1'b0);
    n_sh = 0;
  endtask

  task automatic model_step();
    logic [SRW-1:0] w, cap;
    logic           acc_ok, old_inc;
    if (RESET) begin
      model_reset();
      return;
    end
    for (int i = 0; i < SRW; i++) w[i] = sq[i];
    cap     = word(m_dbg, m_len, m_err, m_inc, m_wr, m_addr);
    old_inc = m_inc;
    acc_ok  = SEL && UPDATE && (n_sh == SRW);
    m_stb   = acc_ok;
    if (SEL && UPDATE && !acc_ok) m_len = 1'b1;
    if (acc_ok) begin
      m_addr = w[31:0];
      m_wr   = w[32];
      m_inc  = w[33];
      if (w[34]) m_err = 1'b0;
      if (w[35]) m_len = 1'b0;
      m_dbg  = w[41:36];
    end else if (ACC && old_inc) begin
      m_addr = m_addr + AW'(STRIDE);
    end
    if (BUS_ERR) m_err = 1'b1;
    if (SEL && CAPTURE) begin
      sq = {};
      for (int i = 0; i < SRW; i++) sq.push_back(cap[i]);
      n_sh = 0;
    end else if (SEL && SHIFT) begin
      void'(sq.pop_front());
      sq.push_back(TDI);
      if (n_sh < 1000) n_sh++;
    end
  endtask

  task automatic check_all();
    chk("DBG",     64'(DBG),     64'(m_dbg));
    chk("INC",     64'(INC),     64'(m_inc));
    chk("WR",      64'(WR),      64'(m_wr));
    chk("ADDR",    64'(ADDR),    64'(m_addr));
    chk("UPD_STB", 64'(UPD_STB), 64'(m_stb));
    chk("ERR",     64'(ERR),     64'(m_err));
    chk("LEN_ERR", 64'(LEN_ERR), 64'(m_len));
    chk("TDO",     64'(TDO),     64'(sq[0]));
  endtask

  task automatic tick();
    @(posedge TCK);
    model_step();
    @(negedge TCK);
    check_all();
  endtask

  task automatic idle();
    SEL = 0; CAPTURE = 0; SHIFT = 0; UPDATE = 0; TDI = 0; ACC = 0; BUS_ERR = 0;
  endtask

  task automatic scan(input logic [SRW-1:0] w, input int nbits, input bit acc_upd,
                      input bit berr_upd, output logic [SRW-1:0] rd);
    rd = '0;
    idle();
    SEL = 1; CAPTURE = 1;
    tick();
    CAPTURE = 0; SHIFT = 1;
    for (int i = 0; i < nbits; i++) begin
      if (i < SRW) begin
        rd[i] = TDO;
        TDI = w[i];
      end else begin
        TDI = 1'b0;
      end
      tick();
    end
    SHIFT = 0; UPDATE = 1; ACC = acc_upd; BUS_ERR = berr_upd;
    tick();
    idle();
  endtask

  logic [SRW-1:0] rd;

  initial begin
    idle();
    RESET = 1;
    model_reset();
    tick();
    tick();
    RESET = 0;
    chk("reset_addr", 64'(ADDR), 64'h0);
    chk("reset_tdo",  64'(TDO),  64'h0);
    tick();

    // Full 42-bit load and readback
    scan(word(6'h2A, 0, 0, 1, 1, 32'h1000_0000), SRW, 0, 0, rd);
    chk("load_addr", 64'(ADDR),    64'h1000_0000);
    chk("load_dbg",  64'(DBG),     64'h2A);
    chk("load_wr",   64'(WR),      64'h1);
    chk("load_inc",  64'(INC),     64'h1);
    chk("load_stb",  64'(UPD_STB), 64'h1);
    tick();
    chk("stb_once",  64'(UPD_STB), 64'h0);
    scan(word(6'h2A, 0, 0, 1, 1, 32'h1000_0000), SRW, 0, 0, rd);
    chk("readback",  64'(rd),      64'h2A3_1000_0000);

    // Auto-increment with wrap
    scan(word(6'h00, 0, 0, 1, 0, 32'hFFFF_FFF8), SRW, 0, 0, rd);
    ACC = 1; tick(); ACC = 0;
    chk("inc1", 64'(ADDR), 64'hFFFF_FFFC);
    ACC = 1; tick(); ACC = 0;
    chk("inc2", 64'(ADDR), 64'h0);
    tick();
    ACC = 1; tick(); ACC = 0;
    chk("inc3", 64'(ADDR), 64'h4);
    scan(word(6'h00, 0, 0, 0, 0, 32'h100), SRW, 0, 0, rd);
    ACC = 1; tick(); ACC = 0;
    chk("noinc", 64'(ADDR), 64'h100);

    // Length checks
    scan(word(6'h15, 0, 0, 1, 1, 32'hABCD), SRW - 1, 0, 0, rd);
    chk("short_addr", 64'(ADDR),    64'h100);
    chk("short_len",  64'(LEN_ERR), 64'h1);
    chk("short_stb",  64'(UPD_STB), 64'h0);
    scan(word(6'h15, 0, 0, 1, 1, 32'hABCD), SRW + 1, 0, 0, rd);
    chk("long_addr",  64'(ADDR),    64'h100);
    chk("long_len",   64'(LEN_ERR), 64'h1);
    scan(word(6'h15, 1, 0, 1, 1, 32'hABCD), SRW, 0, 0, rd);
    chk("clr_len",    64'(LEN_ERR), 64'h0);
    chk("clr_addr",   64'(ADDR),    64'hABCD);
    chk("clr_dbg",    64'(DBG),     64'h15);

    // Sticky bus error, W1C, set-wins
    BUS_ERR = 1; tick(); BUS_ERR = 0;
    chk("err_set", 64'(ERR), 64'h1);
    scan(word(6'h01, 0, 1, 0, 0, 32'h10), SRW, 0, 0, rd);
    chk("err_clr", 64'(ERR), 64'h0);
    BUS_ERR = 1; tick(); BUS_ERR = 0;
    scan(word(6'h01, 0, 1, 0, 0, 32'h10), SRW, 0, 1, rd);
    chk("err_win", 64'(ERR), 64'h1);

    // Update/ACC collision
    scan(word(6'h00, 0, 0, 1, 0, 32'h20), SRW, 0, 0, rd);
    scan(word(6'h00, 0, 0, 1, 0, 32'h40), SRW, 1, 0, rd);
    chk("collide", 64'(ADDR), 64'h40);

    // Zero-length scan
    scan(word(6'h3F, 0, 0, 1, 0, 32'h99), 0, 0, 0, rd);
    chk("zero_len",  64'(LEN_ERR), 64'h1);
    chk("zero_addr", 64'(ADDR),    64'h40);

    // Deselected: TAP strobes ignored, ACC still honoured
    SEL = 0; CAPTURE = 1; UPDATE = 1; ACC = 1;
    tick();
    idle();
    chk("nosel_addr", 64'(ADDR),    64'h44);
    chk("nosel_stb",  64'(UPD_STB), 64'h0);

    // Async reset in the middle of a shift
    SEL = 1; CAPTURE = 1; tick(); CAPTURE = 0;
    SHIFT = 1; TDI = 1;
    for (int i = 0; i < SRW; i++) tick();
    #2 RESET = 1;
    #1;
    chk("ar_tdo",  64'(TDO),     64'h0);
    chk("ar_addr", 64'(ADDR),    64'h0);
    chk("ar_len",  64'(LEN_ERR), 64'h0);
    chk("ar_err",  64'(ERR),     64'h0);
    chk("ar_inc",  64'(INC),     64'h0);
    model_reset();
    tick();
    RESET = 0;
    for (int i = 0; i < 22; i++) tick();
    SHIFT = 0; UPDATE = 1;
    tick();
    idle();
    chk("ar_reject", 64'(LEN_ERR), 64'h1);
    chk("ar_keep",   64'(ADDR),    64'h0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/jtag_addr_reg.md
# jtag_addr_reg

Parametrised JTAG user-data-register for debug address/control, driven by the Xilinx BSCAN TAP decode signals and clocked by TCK. It holds the debug field, INC/WR mode bits and a bus address. It adds address auto-increment on each data-side access, a one-cycle update strobe, a sticky bus-error flag (write-1-to-clear), and shift-length checking that rejects malformed updates. It sits between the BSCAN primitive and the debug bus bridge, alongside the data-register chain.

## Interface
Parameters:
- AW, 32, address width (1..64)
- DBGW, 6, debug/opcode field width (1..16)
- STRIDE, 4, address increment per access; applied modulo 2^AW
- SRW, DBGW+4+AW, derived scan length; not overridable

Ports:
- TCK  in  1  TAP clock, all state on rising edge
- RESET  in  1  asynchronous, active-high; TAP reset or system reset
- SEL  in  1  this user register is selected
- CAPTURE  in  1  TAP in Capture-DR
- SHIFT  in  1  TAP in Shift-DR
- UPDATE  in  1  TAP in Update-DR
- TDI  in  1  scan in
- TDO  out  1  scan out, combinational = SR[0]
- ACC  in  1  one-TCK pulse: data-side bus access completed
- BUS_ERR  in  1  one-TCK pulse: data-side access errored
- DBG  out  DBGW  debug field
- INC  out  1  auto-increment enable
- WR  out  1  write mode (0 = read)
- ADDR  out  AW  current bus address
- UPD_STB  out  1  one-cycle pulse after an accepted update
- ERR  out  1  sticky bus error
- LEN_ERR  out  1  sticky scan-length error

## Operation
- Scan layout, LSB first: ADDR[AW-1:0], WR, INC, ERR, LEN_ERR, DBG[DBGW-1:0].
- Capture (SEL&CAPTURE): SR <= current {DBG, LEN_ERR, ERR, INC, WR, ADDR}; shift counter <= 0.
- Shift (SEL&SHIFT, no CAPTURE): SR <= {TDI, SR[SRW-1:1]}; counter increments, saturating at SRW+1.
- Update (SEL&UPDATE):
  - If counter == SRW: accepted. DBG, INC, WR, ADDR load from SR. ERR and LEN_ERR clear where the corresponding SR bit is 1 (W1C). UPD_STB pulses.
  - Otherwise: rejected. Outputs are unchanged, LEN_ERR sets, no UPD_STB.
- Access: ACC & INC & !(SEL&UPDATE accepted) gives ADDR <= ADDR + STRIDE, truncated to AW bits (wraps).
- Errors: BUS_ERR sets ERR. When set and W1C clear coincide, set wins.
- SEL low: CAPTURE/SHIFT/UPDATE are ignored. ACC and BUS_ERR are still honoured.

## Timing
- Reset values: all outputs 0, SR = 0, counter = 0. RESET takes effect immediately and asynchronously; TDO becomes 0.
- Output latency:
  - DBG, INC, WR, ADDR change on the UPDATE edge and are visible the following cycle.
  - UPD_STB is registered: high for exactly one TCK, the cycle after the UPDATE edge.
  - ADDR increment is visible the cycle after the ACC edge.
  - ERR sets the cycle after BUS_ERR.
- Priority when asserted together (illegal in a real TAP, but defined): CAPTURE > SHIFT; UPDATE is evaluated alongside.
- Accepted UPDATE and ACC in the same cycle: the loaded ADDR wins and the increment is dropped.
- Counter saturation: a scan longer than SRW saturates at SRW+1 and is rejected. A scan of 0 bits is rejected.
- RESET mid-scan: SR and counter clear. A later UPDATE without a fresh CAPTURE and SRW shifts is rejected.

## Structure
- Package jtag_dbg_pkg holds:
  - field offsets (ADDR_LSB, WR_BIT, INC_BIT, ERR_BIT, LEN_ERR_BIT, DBG_LSB) as functions of AW/DBGW;
  - the SRW computation;
  - a packed typedef for the capture/update word.
- Single module. The shift counter (width $clog2(SRW+2)) and the increment adder are inline; no sub-module is warranted.

## Test plan
- Reset: assert RESET asynchronously mid-shift. All outputs go to 0 and TDO = 0 without a TCK edge.
- Full scan, AW=32, DBGW=6: capture, shift 42 bits encoding ADDR=0x1000_0000, WR=1, INC=1, DBG=0x2A, then update. Outputs match the next cycle and UPD_STB pulses for exactly 1 cycle. A following capture plus 42 shifts returns the same word on TDO.
- Auto-increment: ADDR=0xFFFF_FFF8, INC=1, STRIDE=4, three ACC pulses. ADDR goes 0xFFFF_FFFC, then 0x0000_0000, then 0x0000_0004. With INC=0, ACC leaves ADDR unchanged.
- Length check: shift 41 bits then update. Outputs are unchanged, LEN_ERR=1, no UPD_STB. Next, a 43-bit scan is also rejected. Next, a 42-bit scan with the LEN_ERR bit = 1 clears LEN_ERR and applies the load.
- Sticky error: BUS_ERR pulse sets ERR. An accepted update with the ERR bit = 1 clears it. BUS_ERR coincident with that clearing update leaves ERR=1.
- Collision: accepted UPDATE loading ADDR=0x40 in the same cycle as ACC with INC=1. ADDR=0x40, not 0x44.
